// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer, memory model and core:
// controller states and the 3x3 window layout {row0,row1,row2}, each row {p0,p1,p2}.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int ROW_W = 3 * PIX_W;
  localparam int WIN_W = 3 * ROW_W;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FEED,
    WAIT_RES,
    WRITE,
    NEXT,
    FINISH
  } state_t;

endpackage

// File: rtl/sobel_scan_cnt.sv
// Raster-order pixel position tracker: x, y and linear pixel address, plus
// last-pixel and interior-pixel flags for the current position.
module sobel_scan_cnt #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              last,
  output logic              interior
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // pix_addr runs alongside x/y so no y*IMG_W product is ever needed
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x        <= '0;
      y        <= '0;
      pix_addr <= '0;
    end else if (advance) begin
      pix_addr <= pix_addr + 1'b1;
      if (x == X_MAX) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign last     = (x == X_MAX) && (y == Y_MAX);
  assign interior = (x != '0) && (x != X_MAX) && (y != '0) && (y != Y_MAX);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: reads each interior 3x3 window, feeds the Sobel core, and
// writes its magnitude (or 0 for border pixels) into the output image region.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int                IMG_W    = 8,
  parameter int                IMG_H    = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data_strobe,
  output logic              mem_bus_rw,
  input  logic [WIN_W-1:0]  mem_bus_out,
  output logic [PIX_W-1:0]  mem_bus_in,
  input  logic              mem_ack,
  output logic [WIN_W-1:0]  bus_in,
  output logic              data_strobe,
  input  logic [PIX_W-1:0]  bus_out,
  input  logic              result_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t            state;
  logic [TW-1:0]     tmo_cnt;
  logic              frame_end;
  logic [ADDR_W-1:0] pix_addr;
  logic              last;
  logic              interior;
  logic              scan_clear;
  logic              scan_adv;

  // The position moves on the write ack, so NEXT already sees the new pixel's flags
  assign scan_clear = (state == IDLE) && start;
  assign scan_adv   = (state == WRITE) && mem_ack && !last;

  sobel_scan_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .clear    (scan_clear),
    .advance  (scan_adv),
    .pix_addr (pix_addr),
    .last     (last),
    .interior (interior)
  );

  // mem_bus_in doubles as the write register; bus_in doubles as the window register
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      mem_data_strobe <= 1'b0;
      mem_bus_rw      <= 1'b1;
      mem_addr        <= '0;
      mem_bus_in      <= '0;
      data_strobe     <= 1'b0;
      bus_in          <= '0;
      tmo_cnt         <= '0;
      frame_end       <= 1'b0;
    end else begin
      done        <= 1'b0;
      data_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          // pixel (0,0) is a corner, so every frame opens with a border write
          if (start) begin
            busy            <= 1'b1;
            error           <= 1'b0;
            frame_end       <= 1'b0;
            mem_data_strobe <= 1'b1;
            mem_bus_rw      <= 1'b0;
            mem_addr        <= OUT_BASE;
            mem_bus_in      <= '0;
            state           <= WRITE;
          end
        end
        READ: begin
          if (mem_ack) begin
            mem_data_strobe <= 1'b0;
            bus_in          <= mem_bus_out;
            data_strobe     <= 1'b1;
            state           <= FEED;
          end
        end
        FEED: begin
          tmo_cnt <= '0;
          state   <= WAIT_RES;
        end
        WAIT_RES: begin
          if (result_valid || tmo_cnt == TMO_LAST) begin
            mem_bus_in      <= result_valid ? bus_out : 8'hFF;
            error           <= error | !result_valid;
            mem_data_strobe <= 1'b1;
            mem_bus_rw      <= 1'b0;
            mem_addr        <= OUT_BASE + pix_addr;
            state           <= WRITE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_data_strobe <= 1'b0;
            frame_end       <= last;
            state           <= NEXT;
          end
        end
        NEXT: begin
          if (frame_end) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end else if (interior) begin
            mem_data_strobe <= 1'b1;
            mem_bus_rw      <= 1'b1;
            mem_addr        <= pix_addr;
            state           <= READ;
          end else begin
            mem_data_strobe <= 1'b1;
            mem_bus_rw      <= 1'b0;
            mem_addr        <= OUT_BASE + pix_addr;
            mem_bus_in      <= '0;
            state           <= WRITE;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: 4x4 and 3x3 instances, each with a memory model
// holding pixel value = address and a core model returning the window centre after L cycles.
module tb_sobel_frame_ctrl;

  localparam int L = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] mkwin(input int a, input int w);
    logic [71:0] win;
    int x, y;
    x   = a % w;
    y   = a / w;
    win = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win = {win[63:0], 8'(((y - 1 + r) * w + (x - 1 + c)) & 255)};
    return win;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 0) ? 4 : 3;

    logic        start, busy, done, error, strobe, rw, ack, ds;
    logic        core_rv, spur_rv, rv;
    logic [15:0] addr;
    logic [7:0]  wdat, core_dat, bus_out;
    logic [71:0] rdwin, bus_in;
    int          delay;
    bit          core_on;
    int          writes, reads, rd_last, done_cnt, done_cyc, fs_cyc;
    int          stab_err, order_err, feed_bad, wmin, wmax, err_at_done;
    logic [7:0]  img [16];

    assign rv      = core_rv | spur_rv;
    assign bus_out = core_rv ? core_dat : 8'h77;

    sobel_frame_ctrl #(
      .IMG_W(W), .IMG_H(W), .ADDR_W(16), .OUT_BASE(16'h8000), .TIMEOUT(15)
    ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .error(error), .mem_addr(addr), .mem_data_strobe(strobe), .mem_bus_rw(rw),
      .mem_bus_out(rdwin), .mem_bus_in(wdat), .mem_ack(ack), .bus_in(bus_in),
      .data_strobe(ds), .bus_out(bus_out), .result_valid(rv)
    );

    // memory model plus per-frame statistics, sampled 1 time unit after each edge
    initial begin
      int w, fcyc, dur;
      logic pbusy, fpend, q_rw;
      logic [15:0] q_addr;
      logic [7:0] q_dat;
      ack = 1'b0; rdwin = '0; w = 0; pbusy = 1'b0; fpend = 1'b0; fcyc = 0;
      writes = 0; reads = 0; rd_last = 0; done_cnt = 0; done_cyc = 0; fs_cyc = 0;
      stab_err = 0; order_err = 0; wmin = 1000; wmax = 0; err_at_done = 0;
      q_rw = 1'b0; q_addr = '0; q_dat = '0;
      forever begin
        @(posedge clk); #1;
        if (busy && !pbusy) begin
          writes = 0; reads = 0; rd_last = 0; done_cnt = 0; fs_cyc = cyc;
          stab_err = 0; order_err = 0; wmin = 1000; wmax = 0; fpend = 1'b0;
          for (int i = 0; i < 16; i++) img[i] = 8'hEE;
        end
        pbusy = busy;
        if (done) begin
          done_cnt++; done_cyc = cyc; err_at_done = int'(error);
        end
        if (ds) begin
          fpend = 1'b1; fcyc = cyc;
        end
        if (ack) begin
          ack = 1'b0; w = 0;
        end else if (strobe) begin
          w++;
          if (w == 1) begin
            q_addr = addr; q_rw = rw; q_dat = wdat;
            if (!rw && fpend) begin
              dur = cyc - fcyc - 1;
              if (dur < wmin) wmin = dur;
              if (dur > wmax) wmax = dur;
              fpend = 1'b0;
            end
          end else if (addr != q_addr || rw != q_rw || (!rw && wdat != q_dat)) begin
            stab_err++;
          end
          if (w >= delay + 2) begin
            ack = 1'b1;
            if (rw) begin
              reads++; rd_last = int'(addr); rdwin = mkwin(int'(addr), W);
            end else begin
              if (int'(addr) - 32768 != writes) order_err++;
              if (int'(addr) >= 32768 && int'(addr) < 32768 + 16) img[int'(addr) - 32768] = wdat;
              writes++;
            end
          end
        end else begin
          w = 0;
        end
      end
    end

    // core model: answers L cycles after the FEED cycle with the centre pixel
    initial begin
      core_rv = 1'b0; core_dat = '0; feed_bad = 0;
      forever begin
        @(posedge clk); #1;
        if (ds) begin
          if (bus_in != mkwin(rd_last, W)) feed_bad++;
          if (core_on) begin
            repeat (L) @(posedge clk);
            #1 core_rv = 1'b1; core_dat = bus_in[39:32];
            @(posedge clk);
            #1 core_rv = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_img0(input bit core_on, input string tag);
    for (int a = 0; a < 16; a++) begin
      int x, y, e;
      x = a % 4;
      y = a / 4;
      e = (x >= 1 && x <= 2 && y >= 1 && y <= 2) ? (core_on ? a : 255) : 0;
      chk($sformatf("%s img[%0d]", tag, a), longint'(u[0].img[a]), e);
    end
  endtask

  task automatic run0(input bit poke);
    bit seen, poked;
    @(posedge clk); #1 u[0].start = 1'b1;
    @(posedge clk); #1 u[0].start = 1'b0;
    chk("start busy", u[0].busy, 1);
    chk("start strobe", u[0].strobe, 1);
    chk("start addr", u[0].addr, 16'h8000);
    chk("start rw", u[0].rw, 0);
    chk("start error clear", u[0].error, 0);
    seen = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      if (u[0].done) begin
        seen = 1'b1;
      end else if (poke && !poked && u[0].strobe && u[0].rw) begin
        poked = 1'b1;
        u[0].start = 1'b1; u[0].spur_rv = 1'b1;
        @(posedge clk); #1 u[0].start = 1'b0; u[0].spur_rv = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("done within budget", seen, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int delay;
    bit core_on;
    int exp_err;
    int exp_reads;
    int exp_wait;
    int exp_cycles;
  } vec_t;

  initial begin
    vec_t tbl[3];
    int n, prs;
    bit seen;

    // 4x4 frame: 12 border x (2+d+1) + 4 interior x ((2+d)+1+wait+(2+d)+1)
    tbl[0] = '{delay: 0, core_on: 1'b1, exp_err: 0, exp_reads: 4, exp_wait: L,  exp_cycles: 68};
    tbl[1] = '{delay: 0, core_on: 1'b0, exp_err: 1, exp_reads: 4, exp_wait: 15, exp_cycles: 120};
    tbl[2] = '{delay: 5, core_on: 1'b1, exp_err: 0, exp_reads: 4, exp_wait: L,  exp_cycles: 168};

    reset = 1'b1;
    u[0].start = 1'b0; u[0].spur_rv = 1'b0; u[0].delay = 0; u[0].core_on = 1'b1;
    u[1].start = 1'b0; u[1].spur_rv = 1'b0; u[1].delay = 0; u[1].core_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", u[0].busy, 0);
    chk("rst done", u[0].done, 0);
    chk("rst error", u[0].error, 0);
    chk("rst strobe", u[0].strobe, 0);
    chk("rst rw", u[0].rw, 1);
    chk("rst addr", u[0].addr, 0);
    chk("rst wdat", u[0].wdat, 0);
    chk("rst data_strobe", u[0].ds, 0);
    chk("rst bus_in zero", u[0].bus_in == '0, 1);
    reset = 1'b0;

    for (int t = 0; t < 3; t++) begin
      string s;
      s = $sformatf("vec%0d", t);
      u[0].delay = tbl[t].delay;
      u[0].core_on = tbl[t].core_on;
      run0(1'b0);
      chk({s, " writes"}, u[0].writes, 16);
      chk({s, " reads"}, u[0].reads, tbl[t].exp_reads);
      chk({s, " done pulses"}, u[0].done_cnt, 1);
      chk({s, " error at done"}, u[0].err_at_done, tbl[t].exp_err);
      chk({s, " min wait"}, u[0].wmin, tbl[t].exp_wait);
      chk({s, " max wait"}, u[0].wmax, tbl[t].exp_wait);
      chk({s, " frame cycles"}, u[0].done_cyc - u[0].fs_cyc, tbl[t].exp_cycles);
      chk({s, " request stable"}, u[0].stab_err, 0);
      chk({s, " write order"}, u[0].order_err, 0);
      chk_img0(tbl[t].core_on, s);
    end

    // reset while the third write request is outstanding
    u[0].delay = 0;
    u[0].core_on = 1'b1;
    @(posedge clk); #1 u[0].start = 1'b1;
    @(posedge clk); #1 u[0].start = 1'b0;
    n = 1;
    prs = 1;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(posedge clk); #1;
      if (u[0].strobe && !u[0].rw && prs == 0) n++;
      prs = int'(u[0].strobe);
    end
    chk("third write reached", n, 3);
    chk("third write addr", u[0].addr, 16'h8002);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid reset strobe", u[0].strobe, 0);
    chk("mid reset busy", u[0].busy, 0);
    chk("mid reset state", u[0].dut.state, sobel_pkg::IDLE);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no replay strobe", u[0].strobe, 0);
    chk("no replay busy", u[0].busy, 0);
    run0(1'b0);
    chk("rerun writes", u[0].writes, 16);
    chk("rerun order", u[0].order_err, 0);
    chk_img0(1'b1, "rerun");

    // start while busy and a stray result_valid during READ
    run0(1'b1);
    chk("poke done pulses", u[0].done_cnt, 1);
    chk("poke reads", u[0].reads, 4);
    chk("poke writes", u[0].writes, 16);
    chk("poke no restart busy", u[0].busy, 0);
    chk("poke no restart strobe", u[0].strobe, 0);
    chk_img0(1'b1, "poke");
    chk("4x4 feed windows", u[0].feed_bad, 0);

    // 3x3: one interior pixel, done lands in the slot after the ninth pixel's NEXT
    @(posedge clk); #1 u[1].start = 1'b1;
    @(posedge clk); #1 u[1].start = 1'b0;
    chk("3x3 first addr", u[1].addr, 16'h8000);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (u[1].done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("3x3 done within budget", seen, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("3x3 reads", u[1].reads, 1);
    chk("3x3 read addr", u[1].rd_last, 4);
    chk("3x3 writes", u[1].writes, 9);
    chk("3x3 done pulses", u[1].done_cnt, 1);
    chk("3x3 error", u[1].err_at_done, 0);
    chk("3x3 done latency", u[1].done_cyc - u[1].fs_cyc, (L + 6) + 8 * 3);
    chk("3x3 feed windows", u[1].feed_bad, 0);
    for (int a = 0; a < 9; a++)
      chk($sformatf("3x3 img[%0d]", a), longint'(u[1].img[a]), (a == 4) ? 4 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
